// File: rtl/sio_pkg.sv
// sio_pkg: shared types and helpers for the SIO frame transmitter.
//   sio_state_t    - frame FSM states (IDLE, GAP, START, DATA, PAR)
//   SIO_PAR_*      - encodings of the PARITY parameter
//   sio_cnt_width  - width of the slot down-counter for a given gap/data length
package sio_pkg;

    typedef enum logic [2:0] {
        SIO_IDLE  = 3'd0,
        SIO_GAP   = 3'd1,
        SIO_START = 3'd2,
        SIO_DATA  = 3'd3,
        SIO_PAR   = 3'd4
    } sio_state_t;

    localparam int SIO_PAR_NONE = 0;
    localparam int SIO_PAR_EVEN = 1;
    localparam int SIO_PAR_ODD  = 2;

    // The counter has to hold the longer of the gap and the data run.
    function automatic int sio_cnt_width(input int gap_len, input int data_w);
        int longest;
        longest = (gap_len > data_w) ? gap_len : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sio_bit_shifter.sv
// sio_bit_shifter: DATA_W-wide load/shift register feeding the serial line.
//   clk, rst_n  - bit clock, asynchronous active-low reset
//   load        - capture load_data and clear the running parity
//   load_data   - word to serialise
//   shift       - advance one bit; bit_out is folded into the parity first
//   bit_out     - bit that the next shift will consume (MSB or LSB end)
//   parity      - XOR of every bit shifted out since the last load
module sio_bit_shifter #(
    parameter int DATA_W    = 10,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic              bit_out,
    output logic              parity
);

    logic [DATA_W-1:0] sr;

    assign bit_out = (MSB_FIRST != 0) ? sr[DATA_W-1] : sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            parity <= 1'b0;
        end else if (load) begin
            sr     <= load_data;
            parity <= 1'b0;
        end else if (shift) begin
            sr     <= (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);
            parity <= parity ^ bit_out;
        end
    end

endmodule

// File: rtl/sio_frame_tx.sv
// sio_frame_tx: serial test-pattern transmitter. Each frame is GAP_LEN zero
// slots, a '1' start slot, DATA_W data slots and an optional parity slot.
//   SioClk, SioRst_n - bit clock, asynchronous active-low reset
//   TxData, TxValid  - word offered for transmission
//   TxReady          - one-word holding buffer is empty
//   Repeat           - resend the last word when nothing new is held
//   SioDat           - registered serial data
//   Busy             - a frame (gap included) is in progress
//   FrameDone        - one-cycle pulse after the last slot of a frame
//
// Handshake: a word transfers on any rising edge with TxValid && TxReady.
// TxReady is the inverse of the hold_full flop, so it never looks at TxValid;
// the producer may hold TxValid/TxData until it sees the transfer edge.
//
// The state register names the slot currently on SioDat: next_state and the
// next SioDat value are computed together and registered on the same edge.
module sio_frame_tx
    import sio_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int GAP_LEN   = 20,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic              SioClk,
    input  logic              SioRst_n,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    input  logic              Repeat,
    output logic              SioDat,
    output logic              Busy,
    output logic              FrameDone
);

    localparam int CW = sio_cnt_width(GAP_LEN, DATA_W);

    sio_state_t        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              hold_full;
    logic [DATA_W-1:0] hold_word;
    logic [DATA_W-1:0] last_word;
    logic              last_valid;
    logic [DATA_W-1:0] load_word;
    logic              accept;
    logic              sio_dat_n;
    logic              frame_done_n;
    logic              load_sh;
    logic              shift_sh;
    logic              end_frame;
    logic              sh_bit;
    logic              sh_par;

    assign accept    = TxValid && !hold_full;
    assign TxReady   = !hold_full;
    assign Busy      = (state != SIO_IDLE);
    // A freshly held word beats the repeat of the previous one.
    assign load_word = hold_full ? hold_word : last_word;

    sio_bit_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk       (SioClk),
        .rst_n     (SioRst_n),
        .load      (load_sh),
        .load_data (load_word),
        .shift     (shift_sh),
        .bit_out   (sh_bit),
        .parity    (sh_par)
    );

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sio_dat_n    = 1'b0;
        frame_done_n = 1'b0;
        load_sh      = 1'b0;
        shift_sh     = 1'b0;
        end_frame    = 1'b0;
        case (state)
            SIO_IDLE: begin
                if (hold_full) begin
                    state_n = SIO_GAP;
                    cnt_n   = CW'(GAP_LEN - 1);
                end
            end
            SIO_GAP: begin
                if (cnt == '0) begin
                    state_n   = SIO_START;
                    sio_dat_n = 1'b1;
                    load_sh   = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SIO_START: begin
                state_n   = SIO_DATA;
                cnt_n     = CW'(DATA_W - 1);
                sio_dat_n = sh_bit;
                shift_sh  = 1'b1;
            end
            SIO_DATA: begin
                if (cnt != '0) begin
                    cnt_n     = cnt - 1'b1;
                    sio_dat_n = sh_bit;
                    shift_sh  = 1'b1;
                end else if (PARITY != SIO_PAR_NONE) begin
                    // All DATA_W bits have been shifted, so sh_par is complete.
                    state_n   = SIO_PAR;
                    sio_dat_n = (PARITY == SIO_PAR_ODD) ? ~sh_par : sh_par;
                end else begin
                    end_frame = 1'b1;
                end
            end
            SIO_PAR: begin
                end_frame = 1'b1;
            end
            default: begin
                state_n = SIO_IDLE;
            end
        endcase

        if (end_frame) begin
            frame_done_n = 1'b1;
            if (hold_full || (Repeat && last_valid)) begin
                state_n = SIO_GAP;
                cnt_n   = CW'(GAP_LEN - 1);
            end else begin
                state_n = SIO_IDLE;
            end
        end
    end

    always_ff @(posedge SioClk or negedge SioRst_n) begin
        if (!SioRst_n) begin
            state     <= SIO_IDLE;
            cnt       <= '0;
            SioDat    <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            SioDat    <= sio_dat_n;
            FrameDone <= frame_done_n;
        end
    end

    // Holding buffer. It drains on the start edge; TxReady is 0 during that
    // cycle, so a drain and a refill never coincide.
    always_ff @(posedge SioClk or negedge SioRst_n) begin
        if (!SioRst_n) begin
            hold_full  <= 1'b0;
            hold_word  <= '0;
            last_word  <= '0;
            last_valid <= 1'b0;
        end else begin
            if (load_sh && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_word <= TxData;
            end
            if (load_sh) begin
                last_word  <= load_word;
                last_valid <= 1'b1;
            end
        end
    end

endmodule
